// File: rtl/keypad_encoder_pkg.sv
// ============================================================================
// Module      : keypad_encoder_pkg
// Description : Shared widths and FSM state encoding for the keypad encoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package keypad_encoder_pkg;

    localparam int KEY_W   = 10;
    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_STROBE   = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/keypad_encoder_onehot10_to_bcd.sv
// ============================================================================
// Module      : onehot10_to_bcd
// Description : Encodes ten key lines to a BCD index and flags exactly-one-set.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module onehot10_to_bcd
    import keypad_encoder_pkg::*;
(
    input  logic [KEY_W-1:0]   keys,
    output logic [DIGIT_W-1:0] bcd,
    output logic               single
);

    // Lowest set bit wins; only meaningful when single is high.
    always_comb begin
        bcd = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (keys[i]) begin
                bcd = DIGIT_W'(i);
            end
        end
    end

    assign single = (keys != '0) && ((keys & (keys - KEY_W'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/keypad_encoder.sv
// ============================================================================
// Module      : keypad_encoder
// Description : Debounces ten digit keys and emits one active-low load strobe
//               with the BCD digit for each accepted press.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module keypad_encoder
    import keypad_encoder_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [KEY_W-1:0]   keys,
    input  logic               entry_en,
    output logic [DIGIT_W-1:0] data,
    output logic               load,
    output logic               busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [KEY_W-1:0]   sync1;
    logic [KEY_W-1:0]   sample;
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DIGIT_W-1:0] cand;
    logic [DIGIT_W-1:0] sample_bcd;
    logic               sample_single;
    logic               cand_match;

    onehot10_to_bcd u_enc (
        .keys   (sample),
        .bcd    (sample_bcd),
        .single (sample_single)
    );

    assign cand_match = (sample == (KEY_W'(1) << cand));

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1  <= '0;
            sample <= '0;
            state  <= ST_IDLE;
            cnt    <= '0;
            cand   <= '0;
            data   <= '0;
        end else begin
            sync1  <= keys;
            sample <= sync1;
            case (state)
                ST_IDLE: begin
                    if (entry_en && (sample != '0)) begin
                        if (sample_single) begin
                            cand  <= sample_bcd;
                            cnt   <= CNT_W'(1);
                            state <= ST_DEBOUNCE;
                        end else begin
                            cnt   <= '0;
                            state <= ST_RELEASE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (sample == '0) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else if (entry_en && cand_match) begin
                        if (cnt == CNT_LAST) begin
                            data  <= cand;
                            state <= ST_STROBE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt   <= '0;
                        state <= ST_RELEASE;
                    end
                end
                ST_STROBE: begin
                    cnt   <= '0;
                    state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Any bounce back to nonzero restarts the release window.
                    if (sample == '0) begin
                        if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        cnt <= '0;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign load = (state != ST_STROBE);
    assign busy = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_keypad_encoder.sv
// ============================================================================
// Module      : tb_keypad_encoder
// Description : Scoreboard bench for keypad_encoder with DEBOUNCE_CYCLES = 4.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_keypad_encoder;

    localparam int DC = 4;

    typedef struct {
        logic [3:0] d;
        int         cyc;
    } strobe_t;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [9:0] keys = '0;
    logic       entry_en = 1'b1;
    logic [3:0] data;
    logic       load;
    logic       busy;

    int      cyc = 0;
    int      n_vec = 0;
    int      n_err = 0;
    strobe_t exp_q[$];
    strobe_t got_q[$];

    keypad_encoder #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
        .clk      (clk),
        .clr      (clr),
        .keys     (keys),
        .entry_en (entry_en),
        .data     (data),
        .load     (load),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every low cycle of load is captured, so a two-cycle strobe shows up twice.
    always @(negedge clk) begin
        if (load === 1'b0) got_q.push_back('{data, cyc});
    end

    task automatic wait_idle(input string name);
        int t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle_timeout: busy=%b, expected 0 within 60 cycles", name, busy);
        end
    endtask

    task automatic test_reset();
        int k;
        strobe_t e, g;
        clr = 1'b0; keys = 10'h020; entry_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++;
            if (data !== 4'd0 || load !== 1'b1 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_outputs: data=%0d load=%b busy=%b, expected 0/1/0", data, load, busy);
            end
        end
        k = cyc;
        clr = 1'b1;
        exp_q.push_back('{4'd5, k + 2 + DC});
        repeat (10) @(posedge clk);
        #1 keys = '0;
        wait_idle("reset");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL reset_strobe: got none, expected data=%0d cyc=%0d", e.d, e.cyc);
            end else begin
                g = got_q.pop_front();
                if (g.d !== e.d || g.cyc != e.cyc) begin
                    n_err++; $display("FAIL reset_strobe: got data=%0d cyc=%0d, expected data=%0d cyc=%0d", g.d, g.cyc, e.d, e.cyc);
                end
            end
        end
        n_vec++;
        if (got_q.size() != 0) begin
            n_err++; $display("FAIL reset_extra_strobe: got %0d extra, expected 0", got_q.size()); got_q.delete();
        end
    endtask

    task automatic test_clean_press();
        int k;
        strobe_t e, g;
        @(posedge clk); #1;
        k = cyc; keys = 10'h001 << 5;
        exp_q.push_back('{4'd5, k + 2 + DC});
        repeat (10) @(posedge clk);
        #1 keys = '0;
        // zero samples begin at k+13; fourth zero sample returns to idle at k+16
        while (cyc < k + 15) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL clean_busy_hold: busy=%b, expected 1", busy);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || data !== 4'd5) begin
            n_err++; $display("FAIL clean_busy_fall: busy=%b data=%0d, expected 0/5", busy, data);
        end
        repeat (6) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL clean_strobe: got none, expected data=%0d cyc=%0d", e.d, e.cyc);
            end else begin
                g = got_q.pop_front();
                if (g.d !== e.d || g.cyc != e.cyc) begin
                    n_err++; $display("FAIL clean_strobe: got data=%0d cyc=%0d, expected data=%0d cyc=%0d", g.d, g.cyc, e.d, e.cyc);
                end
            end
        end
        n_vec++;
        if (got_q.size() != 0) begin
            n_err++; $display("FAIL clean_extra_strobe: got %0d extra, expected 0", got_q.size()); got_q.delete();
        end
    endtask

    task automatic test_bounce();
        int k;
        strobe_t e, g;
        @(posedge clk); #1;
        k = cyc; keys = 10'h010;
        @(posedge clk); @(posedge clk); #1 keys = '0;
        @(posedge clk); #1 keys = 10'h010;
        // stable samples start at k+6; strobe on the fourth
        exp_q.push_back('{4'd4, k + 6 + DC - 1});
        repeat (8) @(posedge clk);
        #1 keys = '0;
        wait_idle("bounce");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL bounce_strobe: got none, expected data=%0d cyc=%0d", e.d, e.cyc);
            end else begin
                g = got_q.pop_front();
                if (g.d !== e.d || g.cyc != e.cyc) begin
                    n_err++; $display("FAIL bounce_strobe: got data=%0d cyc=%0d, expected data=%0d cyc=%0d", g.d, g.cyc, e.d, e.cyc);
                end
            end
        end
        n_vec++;
        if (got_q.size() != 0) begin
            n_err++; $display("FAIL bounce_extra_strobe: got %0d extra, expected 0", got_q.size()); got_q.delete();
        end
    endtask

    task automatic test_multikey();
        int k;
        @(posedge clk); #1;
        k = cyc; keys = 10'h088;
        repeat (6) @(posedge clk);
        #1 keys = '0;
        while (cyc < k + 11) @(negedge clk);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++; $display("FAIL multi_busy_hold: busy=%b, expected 1", busy);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || data !== 4'd4) begin
            n_err++; $display("FAIL multi_busy_fall: busy=%b data=%0d, expected 0/4", busy, data);
        end
        n_vec++;
        if (got_q.size() != 0) begin
            n_err++; $display("FAIL multi_strobe: got %0d strobes, expected 0", got_q.size()); got_q.delete();
        end
    endtask

    task automatic test_disabled_abort();
        int k;
        int busy_seen = 0;
        @(posedge clk); #1;
        entry_en = 1'b0; keys = 10'h200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        n_vec++;
        if (busy_seen != 0 || got_q.size() != 0) begin
            n_err++; $display("FAIL disabled: busy high %0d cycles, %0d strobes, expected 0/0", busy_seen, got_q.size());
            got_q.delete();
        end
        @(posedge clk); #1 keys = '0;
        repeat (4) @(posedge clk);
        #1 entry_en = 1'b1;
        @(posedge clk); #1;
        k = cyc; keys = 10'h004;
        // sample cycle 0 is k+3, so sample cycle 2 is k+5: one edge before the strobe
        while (cyc < k + 5) @(posedge clk);
        #1 clr = 1'b0;
        #2;
        n_vec++;
        if (data !== 4'd0 || load !== 1'b1 || busy !== 1'b0) begin
            n_err++; $display("FAIL abort_reset: data=%0d load=%b busy=%b, expected 0/1/0", data, load, busy);
        end
        @(posedge clk); #1 keys = '0;
        @(posedge clk); #1 clr = 1'b1;
        repeat (12) @(negedge clk);
        n_vec++;
        if (got_q.size() != 0 || data !== 4'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL abort_strobe: %0d strobes data=%0d busy=%b, expected 0/0/0", got_q.size(), data, busy);
            got_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int k;
        logic [3:0] digits [4];
        strobe_t e, g;
        digits[0] = 4'd5; digits[1] = 4'd4; digits[2] = 4'd3; digits[3] = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            k = cyc; keys = 10'h001 << digits[i];
            exp_q.push_back('{digits[i], k + 2 + DC});
            repeat (6) @(posedge clk);
            #1 keys = '0;
            wait_idle("seq");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_vec++;
            if (got_q.size() == 0) begin
                n_err++; $display("FAIL seq_strobe: got none, expected data=%0d cyc=%0d", e.d, e.cyc);
            end else begin
                g = got_q.pop_front();
                if (g.d !== e.d || g.cyc != e.cyc) begin
                    n_err++; $display("FAIL seq_strobe: got data=%0d cyc=%0d, expected data=%0d cyc=%0d", g.d, g.cyc, e.d, e.cyc);
                end
            end
        end
        n_vec++;
        if (got_q.size() != 0) begin
            n_err++; $display("FAIL seq_extra_strobe: got %0d extra, expected 0", got_q.size()); got_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multikey();
        test_disabled_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
